reg_sum_unit: RTL and testbench
===============================

# reg_sum_unit

Downstream consumer of the SPI register file's write registers. It snapshots the three host-written 16-bit registers when the host signals a completed write, sums them in a small multi-cycle pipeline, and presents the result as the read-back register 0 value. It replaces the free-running combinational adder with a registered result that never changes while an SPI read of that register is in progress, and it adds overflow reporting.

## Interface
- `WIDTH`, default 16: width of each operand and of the result.
- `SATURATE`, default 0: 0 = wrap the result modulo 2^WIDTH; 1 = clamp the result to all-ones.
- `clk`  in  1  system clock; the SPI interface's clock.
- `rst`  in  1  reset, synchronous and active-high.
- `i_reg1`  in  WIDTH  operand A (SPI register 1 output).
- `i_reg2`  in  WIDTH  operand B (SPI register 2 output).
- `i_reg3`  in  WIDTH  operand C (SPI register 3 output).
- `i_wr_stb`  in  1  one-cycle pulse: a host register write has completed.
- `i_rd_busy`  in  1  high while an SPI data read is active; the result must not change while it is high.
- `i_ovf_clr`  in  1  one-cycle pulse: clear the sticky overflow flag.
- `o_reg0`  out  WIDTH  registered result, fed to SPI register 0.
- `o_valid`  out  1  one-cycle pulse on the cycle `o_reg0` updates.
- `o_ovf`  out  1  sticky overflow flag.
- `o_busy`  out  1  high when a computation is in flight or pending.

## Operation
- FSM states: IDLE, SUM1, SUM2, COMMIT.
- **IDLE:** on `i_wr_stb`, capture `i_reg1`, `i_reg2` and `i_reg3` into snapshot registers, then go to SUM1.
- **SUM1:** `p1 = A + B`, held as WIDTH+1 bits. Go to SUM2.
- **SUM2:** `s = p1 + C`, held as WIDTH+2 bits. Go to COMMIT.
- **COMMIT, `i_rd_busy`=1:** stay in COMMIT; `o_reg0` holds its value.
- **COMMIT, `i_rd_busy`=0:** perform the commit and leave COMMIT.
  - Overflow is defined as `s[WIDTH+1:WIDTH] != 0`.
  - `o_reg0` = `s[WIDTH-1:0]`, or all-ones when SATURATE=1 and overflow.
  - `o_ovf` is set to 1 if overflow.
  - `o_valid` pulses.
  - Next state is IDLE, or directly the capture path if a strobe is pending.
- **Strobe outside IDLE:** sets the `pending` flag. Further strobes coalesce into the same flag.
- **Leaving COMMIT with `pending`=1:** `pending` clears, operands are re-captured at that edge from the current inputs, and the FSM goes to SUM1.
- **`i_wr_stb` in the COMMIT exit cycle:** treated as pending, so the next capture follows.
- **`i_ovf_clr`:** clears `o_ovf`. If it coincides with an overflowing commit, set wins and `o_ovf` stays 1.
- **`o_busy`:** `(state != IDLE) | pending`.
- **Operand changes:** changes on `i_reg*` without a strobe are ignored.
- **Reset values:** `o_reg0`=0, `o_valid`=0, `o_ovf`=0, `o_busy`=0, state=IDLE, `pending`=0, snapshots=0.
- **Reset mid-operation:** aborts the computation. There is no commit and no `o_valid`, and the pending strobe is discarded.

## Timing
- Strobe sampled high at edge E0 in IDLE: capture at E0, SUM1 until E1, SUM2 until E2, COMMIT evaluated at E3.
- With `i_rd_busy`=0, `o_reg0` and `o_valid` appear after edge E3. That is 3 cycles of latency from the strobe edge.
- `o_valid` is high for exactly one cycle per commit.
- `i_rd_busy` stall: each cycle it stays high at a COMMIT edge adds one cycle. The commit happens on the first edge at which it is sampled low.
- Back-to-back service: a pending strobe restarts with no IDLE gap. Minimum commit spacing is 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic sum:** reg1=1, reg2=2, reg3=3, strobe → `o_reg0`=0x0006 three cycles after the strobe edge, one `o_valid` pulse, `o_ovf`=0.
- **Wrap and saturate:** three operands of 0xFFFF with SATURATE=0 → `o_reg0`=0xFFFD and `o_ovf`=1. The same operands with SATURATE=1 → `o_reg0`=0xFFFF and `o_ovf`=1. Then `i_ovf_clr` → `o_ovf`=0.
- **Read stall:** result pending while `i_rd_busy`=1 for 10 cycles → `o_reg0` stays at its old value, `o_busy`=1 throughout, commit on the first edge after release.
- **Coalescing:** strobe with (1,1,1); change the operands to (10,20,30) and strobe twice during SUM1/SUM2 → exactly two `o_valid` pulses, with values 3 then 60, and no IDLE cycle between the computations.
- **Clear collision:** `i_ovf_clr` in the same cycle as an overflowing commit → `o_ovf`=1 afterwards.
- **Reset abort:** assert `rst` during SUM2 with a strobe pending → all outputs 0, no `o_valid` after release, and the FSM idles until the next strobe.

Source files
------------

// File: rtl/reg_sum_unit.sv
// rtl/reg_sum_unit.sv - snapshot three host registers and sum them into a stable read-back result
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   i_reg1..i_reg3    operands A, B, C from the host-written registers
//   i_wr_stb          one-cycle pulse when a host register write completes
//   i_rd_busy         high while an SPI read is active; result is frozen
//   i_ovf_clr         one-cycle pulse clearing the sticky overflow flag
//   o_reg0            registered result for read-back register 0
//   o_valid           one-cycle pulse on the cycle o_reg0 updates
//   o_ovf             sticky overflow flag
//   o_busy            computation in flight or a strobe pending
module reg_sum_unit #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_reg1,
    input  logic [WIDTH-1:0] i_reg2,
    input  logic [WIDTH-1:0] i_reg3,
    input  logic             i_wr_stb,
    input  logic             i_rd_busy,
    input  logic             i_ovf_clr,
    output logic [WIDTH-1:0] o_reg0,
    output logic             o_valid,
    output logic             o_ovf,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUM1   = 2'd1,
        SUM2   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH:0]   p1_q, p1_d;
    logic [WIDTH+1:0] s_q, s_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] reg0_q, reg0_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             sum_ovf;

    // Any carry out of the low WIDTH bits of the three-operand sum.
    assign sum_ovf = (s_q[WIDTH+1:WIDTH] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            p1_q      <= '0;
            s_q       <= '0;
            pending_q <= 1'b0;
            reg0_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            p1_q      <= p1_d;
            s_q       <= s_d;
            pending_q <= pending_d;
            reg0_q    <= reg0_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        p1_d      = p1_q;
        s_d       = s_q;
        pending_d = pending_q;
        reg0_d    = reg0_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;

        // Clear first so that an overflowing commit below overrides it.
        if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (i_wr_stb) begin
                    a_d     = i_reg1;
                    b_d     = i_reg2;
                    c_d     = i_reg3;
                    state_d = SUM1;
                end
            end
            SUM1: begin
                p1_d    = {1'b0, a_q} + {1'b0, b_q};
                state_d = SUM2;
                if (i_wr_stb) begin
                    pending_d = 1'b1;
                end
            end
            SUM2: begin
                s_d     = {1'b0, p1_q} + {2'b00, c_q};
                state_d = COMMIT;
                if (i_wr_stb) begin
                    pending_d = 1'b1;
                end
            end
            COMMIT: begin
                if (i_rd_busy) begin
                    if (i_wr_stb) begin
                        pending_d = 1'b1;
                    end
                end else begin
                    reg0_d  = (SATURATE && sum_ovf) ? {WIDTH{1'b1}} : s_q[WIDTH-1:0];
                    valid_d = 1'b1;
                    if (sum_ovf) begin
                        ovf_d = 1'b1;
                    end
                    // A strobe landing on the exit edge is folded into the
                    // pending request so the restart needs no IDLE cycle.
                    if (pending_q || i_wr_stb) begin
                        a_d       = i_reg1;
                        b_d       = i_reg2;
                        c_d       = i_reg3;
                        pending_d = 1'b0;
                        state_d   = SUM1;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_reg0  = reg0_q;
    assign o_valid = valid_q;
    assign o_ovf   = ovf_q;
    assign o_busy  = (state_q != IDLE) | pending_q;

endmodule

// File: tb/tb_reg_sum_unit.sv
// tb/tb_reg_sum_unit.sv - self-checking bench for reg_sum_unit (wrap and saturate instances)
module tb_reg_sum_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] reg1 = '0, reg2 = '0, reg3 = '0;
    logic        stb = 1'b0, rd_busy = 1'b0, clr = 1'b0;

    logic [15:0] r0_0, r0_1;
    logic        v0, v1, ovf0, ovf1, busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_sum_unit #(.WIDTH(16), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .i_reg1(reg1), .i_reg2(reg2), .i_reg3(reg3),
        .i_wr_stb(stb), .i_rd_busy(rd_busy), .i_ovf_clr(clr),
        .o_reg0(r0_0), .o_valid(v0), .o_ovf(ovf0), .o_busy(busy0)
    );

    reg_sum_unit #(.WIDTH(16), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .i_reg1(reg1), .i_reg2(reg2), .i_reg3(reg3),
        .i_wr_stb(stb), .i_rd_busy(rd_busy), .i_ovf_clr(clr),
        .o_reg0(r0_1), .o_valid(v1), .o_ovf(ovf1), .o_busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a job is a snapshot plus a cycle count until
    // it may commit; extra strobes just raise one pending request.
    int          m_phase = 0;   // 0 idle, 1..2 summing, 3 waiting to commit
    logic [15:0] m_a = '0, m_b = '0, m_c = '0;
    bit          m_pend = 0;
    logic [15:0] m_reg0_w = '0, m_reg0_s = '0;
    bit          m_valid = 0, m_ovf = 0, m_busy = 0;
    bit          chk_en = 0;
    int          cyc_n = 0;

    always @(posedge clk) begin
        int sum;
        cyc_n++;
        chk_en = 1;
        if (rst) begin
            m_phase = 0; m_a = '0; m_b = '0; m_c = '0; m_pend = 0;
            m_reg0_w = '0; m_reg0_s = '0; m_valid = 0; m_ovf = 0;
        end else begin
            m_valid = 0;
            if (clr) m_ovf = 0;
            if (m_phase == 0) begin
                if (stb) begin
                    m_a = reg1; m_b = reg2; m_c = reg3; m_phase = 1;
                end
            end else if (m_phase < 3) begin
                m_phase++;
                if (stb) m_pend = 1;
            end else if (rd_busy) begin
                if (stb) m_pend = 1;
            end else begin
                sum = int'(m_a) + int'(m_b) + int'(m_c);
                m_reg0_w = sum[15:0];
                m_reg0_s = (sum > 65535) ? 16'hFFFF : sum[15:0];
                m_valid  = 1;
                if (sum > 65535) m_ovf = 1;
                if (m_pend || stb) begin
                    m_a = reg1; m_b = reg2; m_c = reg3; m_pend = 0; m_phase = 1;
                end else begin
                    m_phase = 0;
                end
            end
        end
        m_busy = (m_phase != 0) || m_pend;
    end

    logic [15:0] vq0[$];
    int          vcyc[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("reg0_wrap", r0_0, m_reg0_w);
            check("reg0_sat",  r0_1, m_reg0_s);
            check("valid_wrap", v0, m_valid);
            check("valid_sat",  v1, m_valid);
            check("ovf_wrap", ovf0, m_ovf);
            check("ovf_sat",  ovf1, m_ovf);
            check("busy_wrap", busy0, m_busy);
            check("busy_sat",  busy1, m_busy);
            if (v0 === 1'b1) begin
                vq0.push_back(r0_0);
                vcyc.push_back(cyc_n);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        @(negedge clk);
        reg1 = a; reg2 = b; reg3 = c; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
    endtask

    initial begin
        int base;
        cycles(3);
        rst = 1'b0;
        check("rst_reg0", r0_0, 16'h0000);
        check("rst_busy", busy0, 1'b0);
        check("rst_ovf",  ovf0, 1'b0);

        // basic sum, three-cycle latency
        strobe(16'd1, 16'd2, 16'd3);
        check("basic_early_valid", v0, 1'b0);
        cycles(3);
        check("basic_valid", v0, 1'b1);
        check("basic_reg0", r0_0, 16'h0006);
        check("basic_ovf", ovf0, 1'b0);
        cycles(1);
        check("basic_one_pulse", v0, 1'b0);

        // wrap vs saturate, then clear
        strobe(16'hFFFF, 16'hFFFF, 16'hFFFF);
        cycles(3);
        check("wrap_reg0", r0_0, 16'hFFFD);
        check("sat_reg0",  r0_1, 16'hFFFF);
        check("wrap_ovf",  ovf0, 1'b1);
        check("sat_ovf",   ovf1, 1'b1);
        cycles(1);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check("ovf_cleared", ovf0, 1'b0);

        // read stall
        rd_busy = 1'b1;
        strobe(16'd5, 16'd5, 16'd5);
        cycles(10);
        check("stall_hold", r0_0, 16'hFFFD);
        check("stall_busy", busy0, 1'b1);
        check("stall_no_valid", v0, 1'b0);
        rd_busy = 1'b0;
        cycles(1);
        check("stall_valid", v0, 1'b1);
        check("stall_reg0", r0_0, 16'd15);
        cycles(2);

        // coalescing: strobes during SUM1 and SUM2 collapse to one rerun
        base = vq0.size();
        @(negedge clk); reg1 = 16'd1;  reg2 = 16'd1;  reg3 = 16'd1;  stb = 1'b1;
        @(negedge clk); reg1 = 16'd10; reg2 = 16'd20; reg3 = 16'd30; stb = 1'b1;
        @(negedge clk); stb = 1'b1;
        @(negedge clk); stb = 1'b0;
        cycles(8);
        check("coalesce_count", vq0.size() - base, 2);
        if (vq0.size() - base == 2) begin
            check("coalesce_first",  vq0[base],   16'd3);
            check("coalesce_second", vq0[base+1], 16'd60);
            check("coalesce_gap", vcyc[base+1] - vcyc[base], 3);
        end

        // clear colliding with an overflowing commit: set wins
        strobe(16'hFFFF, 16'hFFFF, 16'hFFFF);
        cycles(2);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check("collide_valid", v0, 1'b1);
        check("collide_ovf", ovf0, 1'b1);
        cycles(1);
        check("collide_ovf_hold", ovf0, 1'b1);

        // reset during SUM2 with a strobe pending
        base = vq0.size();
        @(negedge clk); reg1 = 16'd1; reg2 = 16'd2; reg3 = 16'd3; stb = 1'b1;
        @(negedge clk); stb = 1'b1;
        @(negedge clk); stb = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort_reg0", r0_0, 16'h0000);
        check("abort_ovf",  ovf0, 1'b0);
        check("abort_busy", busy0, 1'b0);
        cycles(6);
        check("abort_no_valid", vq0.size() - base, 0);
        check("abort_idle", busy0, 1'b0);
        strobe(16'd2, 16'd2, 16'd2);
        cycles(3);
        check("after_abort_valid", v0, 1'b1);
        check("after_abort_reg0", r0_0, 16'd6);
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
